// File: rtl/fram_req_queue.sv
// fram_req_queue: request FIFO feeding a single-outstanding FRAM command FSM with timeout
module fram_req_queue #(
  parameter int DEPTH = 4,
  parameter int ADDR_W = 11,
  parameter int DATA_W = 32,
  parameter int TIMEOUT = 65535
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic [ADDR_W-1:0]       req_addr,
  input  logic [DATA_W-1:0]       req_wdata,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic                    rsp_write,
  output logic [ADDR_W-1:0]       rsp_addr,
  output logic [DATA_W-1:0]       rsp_rdata,
  output logic                    rsp_timeout,
  output logic                    mem_start,
  output logic                    mem_write_enable,
  output logic                    mem_read_enable,
  output logic [ADDR_W-1:0]       mem_address,
  output logic [DATA_W-1:0]       mem_data_in,
  input  logic                    mem_busy,
  input  logic [DATA_W-1:0]       mem_data_out,
  output logic [$clog2(DEPTH):0]  level
);
  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam int EW = 1 + ADDR_W + DATA_W;
  localparam logic [15:0] LAST = 16'(TIMEOUT - 1);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  state_t state, state_nxt;
  logic [EW-1:0] fifo [DEPTH];
  logic [EW-1:0] head;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [LW-1:0] level_nxt;
  logic [15:0] cnt, cnt_nxt;
  logic push, pop, done, op, op_nxt;
  logic start_nxt, we_nxt, re_nxt, rsp_write_nxt, tmo_nxt;
  logic [ADDR_W-1:0] addr_nxt, rsp_addr_nxt;
  logic [DATA_W-1:0] wdata_nxt, rdata_nxt;

  assign push = req_valid && req_ready;
  assign head = fifo[rd_ptr];
  assign level_nxt = level + LW'(push) - LW'(pop);
  assign done = state == WAIT && !mem_busy;
  assign rsp_valid = state == RESP;

  always_ff @(posedge clk)
    if (push) fifo[wr_ptr] <= {req_write, req_addr, req_wdata};

  // ready is a register so a same-cycle pop never reopens a full FIFO
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level <= '0;
      req_ready <= 1'b0;
    end else begin
      wr_ptr <= wr_ptr + PW'(push);
      rd_ptr <= rd_ptr + PW'(pop);
      level <= level_nxt;
      req_ready <= level_nxt != LW'(DEPTH);
    end

  always_comb begin
    state_nxt = state;
    pop = 1'b0;
    cnt_nxt = cnt;
    op_nxt = op;
    start_nxt = mem_start;
    we_nxt = mem_write_enable;
    re_nxt = mem_read_enable;
    addr_nxt = mem_address;
    wdata_nxt = mem_data_in;
    rsp_write_nxt = rsp_write;
    rsp_addr_nxt = rsp_addr;
    rdata_nxt = rsp_rdata;
    tmo_nxt = rsp_timeout;
    case (state)
      IDLE: if (level != '0) begin
        pop = 1'b1;
        {op_nxt, addr_nxt, wdata_nxt} = head;
        start_nxt = 1'b1;
        we_nxt = head[EW-1];
        re_nxt = !head[EW-1];
        cnt_nxt = '0;
        state_nxt = ISSUE;
      end
      ISSUE, WAIT: begin
        cnt_nxt = cnt + 16'd1;
        if (state == ISSUE && mem_busy) begin
          start_nxt = 1'b0;
          state_nxt = WAIT;
        end else if (done || cnt >= LAST) begin
          // >= covers an acknowledge that landed exactly on the last ISSUE count
          start_nxt = 1'b0;
          we_nxt = 1'b0;
          re_nxt = 1'b0;
          rsp_write_nxt = op;
          rsp_addr_nxt = mem_address;
          rdata_nxt = done && !op ? mem_data_out : '0;
          tmo_nxt = !done;
          state_nxt = RESP;
        end
      end
      RESP: if (rsp_ready) state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      op <= 1'b0;
      mem_start <= 1'b0;
      mem_write_enable <= 1'b0;
      mem_read_enable <= 1'b0;
      mem_address <= '0;
      mem_data_in <= '0;
      rsp_write <= 1'b0;
      rsp_addr <= '0;
      rsp_rdata <= '0;
      rsp_timeout <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt <= cnt_nxt;
      op <= op_nxt;
      mem_start <= start_nxt;
      mem_write_enable <= we_nxt;
      mem_read_enable <= re_nxt;
      mem_address <= addr_nxt;
      mem_data_in <= wdata_nxt;
      rsp_write <= rsp_write_nxt;
      rsp_addr <= rsp_addr_nxt;
      rsp_rdata <= rdata_nxt;
      rsp_timeout <= tmo_nxt;
    end
endmodule

// File: tb/tb_fram_req_queue.sv
// tb_fram_req_queue: table vectors, back-pressure, timeout and reset sequences, random traffic vs a queue model
`timescale 1ns/1ps
module tb_fram_req_queue;
  localparam int AW = 11;
  localparam int DW = 32;
  typedef struct packed {logic w; logic [AW-1:0] a; logic [DW-1:0] d;} exp_t;
  typedef struct {logic w; logic [AW-1:0] a; logic [DW-1:0] d; int dly; int len; logic [DW-1:0] rd;} vec_t;

  logic clk = 1'b0, rst_n = 1'b0;
  logic req_valid = 1'b0, req_write = 1'b0, rsp_ready = 1'b0, mem_busy = 1'b0;
  logic t_valid = 1'b0, t_rsp_ready = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0, mem_data_out = '0;
  logic req_ready, rsp_valid, rsp_write, rsp_timeout, mem_start, mem_write_enable, mem_read_enable;
  logic [AW-1:0] rsp_addr, mem_address;
  logic [DW-1:0] rsp_rdata, mem_data_in;
  logic [2:0] level;
  logic t_req_ready, t_rsp_valid, t_rsp_write, t_rsp_timeout, t_mem_start, t_mem_we, t_mem_re;
  logic [AW-1:0] t_rsp_addr, t_mem_address;
  logic [DW-1:0] t_rsp_rdata, t_mem_data_in;
  logic [2:0] t_level;

  int checks = 0, failures = 0, pushes = 0, resps = 0;
  logic [DW-1:0] store [2048];
  logic [DW-1:0] ref_mem [2048];
  exp_t sbq [$];
  int dly = 1, len = 1, k = 0;
  bit trk = 1'b0, rand_lat = 1'b0;
  vec_t vt [7];

  always #5 clk = ~clk;

  fram_req_queue #(.DEPTH(4), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(64)) u_dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_write(rsp_write), .rsp_addr(rsp_addr), .rsp_rdata(rsp_rdata), .rsp_timeout(rsp_timeout),
    .mem_start(mem_start), .mem_write_enable(mem_write_enable), .mem_read_enable(mem_read_enable),
    .mem_address(mem_address), .mem_data_in(mem_data_in), .mem_busy(mem_busy),
    .mem_data_out(mem_data_out), .level(level));

  fram_req_queue #(.DEPTH(4), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(16)) u_tmo (
    .clk(clk), .rst_n(rst_n), .req_valid(t_valid), .req_ready(t_req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(t_rsp_valid), .rsp_ready(t_rsp_ready),
    .rsp_write(t_rsp_write), .rsp_addr(t_rsp_addr), .rsp_rdata(t_rsp_rdata), .rsp_timeout(t_rsp_timeout),
    .mem_start(t_mem_start), .mem_write_enable(t_mem_we), .mem_read_enable(t_mem_re),
    .mem_address(t_mem_address), .mem_data_in(t_mem_data_in), .mem_busy(1'b0),
    .mem_data_out(32'hDEADBEEF), .level(t_level));

  // memory controller model: busy rises dly cycles after start is seen and lasts len cycles
  always @(negedge clk) begin
    if (!rst_n) begin
      trk = 1'b0;
      mem_busy = 1'b0;
    end else begin
      if (!trk && mem_start) begin
        trk = 1'b1;
        k = 0;
        if (rand_lat) begin
          dly = $urandom_range(0, 3);
          len = $urandom_range(1, 4);
        end
        if (mem_write_enable) store[mem_address] = mem_data_in;
        else mem_data_out = store[mem_address];
      end else if (trk) k++;
      if (trk) begin
        mem_busy = k >= dly && k < dly + len;
        if (k >= dly + len) trk = 1'b0;
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // one cycle: score handshakes visible now, then advance to the next falling edge
  task automatic tick();
    exp_t e;
    if (req_valid && req_ready) begin
      sbq.push_back({req_write, req_addr, req_write ? 32'h0 : ref_mem[req_addr]});
      if (req_write) ref_mem[req_addr] = req_wdata;
      pushes++;
    end
    if (rsp_valid && rsp_ready) begin
      resps++;
      checks++;
      if (sbq.size() == 0) begin
        failures++;
        $display("FAIL rsp_unexpected: got addr 0x%0h expected no response", rsp_addr);
      end else begin
        e = sbq.pop_front();
        if ({rsp_write, rsp_addr, rsp_rdata, rsp_timeout} !== {e, 1'b0}) begin
          failures++;
          $display("FAIL rsp_order: got w=%0b a=0x%0h d=0x%0h t=%0b expected w=%0b a=0x%0h d=0x%0h t=0",
                   rsp_write, rsp_addr, rsp_rdata, rsp_timeout, e.w, e.a, e.d);
        end
      end
    end
    chk("enables_exclusive", 64'(mem_write_enable && mem_read_enable), 64'(0));
    @(negedge clk);
  endtask

  task automatic run_vec(input vec_t v);
    int n;
    dly = v.dly;
    len = v.len;
    req_valid = 1'b1;
    req_write = v.w;
    req_addr = v.a;
    req_wdata = v.d;
    tick();
    req_valid = 1'b0;
    chk("vec_level", 64'(level), 64'(1));
    n = 0;
    while (!mem_start && n < 10) begin tick(); n++; end
    chk("vec_start_latency", 64'(n), 64'(1));
    chk("vec_enables", 64'({mem_write_enable, mem_read_enable}), 64'({v.w, !v.w}));
    chk("vec_mem_addr", 64'(mem_address), 64'(v.a));
    if (v.w) chk("vec_mem_wdata", 64'(mem_data_in), 64'(v.d));
    n = 0;
    while (!rsp_valid && n < 100) begin tick(); n++; end
    chk("vec_rsp_valid", 64'(rsp_valid), 64'(1));
    chk("vec_rsp", 64'({rsp_write, rsp_addr, rsp_rdata, rsp_timeout}), 64'({v.w, v.a, v.rd, 1'b0}));
    chk("vec_strobes_clear", 64'({mem_start, mem_write_enable, mem_read_enable}), 64'(0));
    tick();
    chk("vec_rsp_drop", 64'(rsp_valid), 64'(0));
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, acc, seen, p0, r0;
    for (int i = 0; i < 2048; i++) begin
      store[i] = 32'hC0DE0000 | 32'(i);
      ref_mem[i] = 32'hC0DE0000 | 32'(i);
    end
    vt[0] = '{1'b1, 11'h005, 32'hA5A5A5A5, 1, 20, 32'h0};
    vt[1] = '{1'b0, 11'h005, 32'h0, 1, 20, 32'hA5A5A5A5};
    vt[2] = '{1'b1, 11'h7FF, 32'h12345678, 0, 1, 32'h0};
    vt[3] = '{1'b0, 11'h7FF, 32'h0, 0, 1, 32'h12345678};
    vt[4] = '{1'b0, 11'h100, 32'h0, 2, 3, 32'hC0DE0100};
    vt[5] = '{1'b1, 11'h000, 32'hFFFFFFFF, 3, 5, 32'h0};
    vt[6] = '{1'b0, 11'h000, 32'h0, 0, 4, 32'hFFFFFFFF};

    repeat (3) @(negedge clk);
    chk("reset_level", 64'(level), 64'(0));
    chk("reset_ready", 64'(req_ready), 64'(0));
    chk("reset_outputs", 64'({rsp_valid, mem_start, mem_write_enable, mem_read_enable}), 64'(0));
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", 64'(req_ready), 64'(1));

    rsp_ready = 1'b1;
    foreach (vt[i]) run_vec(vt[i]);

    // back-pressure: one response parked in RESP, then four fill the FIFO
    rsp_ready = 1'b0;
    dly = 0;
    len = 2;
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr = 11'h040;
    tick();
    req_valid = 1'b0;
    n = 0;
    while (!rsp_valid && n < 50) begin tick(); n++; end
    chk("bp_rsp_parked", 64'(rsp_valid), 64'(1));
    acc = 0;
    n = 0;
    while (acc < 4 && n < 20) begin
      req_valid = 1'b1;
      req_write = 1'b1;
      req_addr = 11'h050 + 11'(acc);
      req_wdata = 32'hB0000000 + 32'(acc);
      if (req_ready) acc++;
      tick();
      n++;
    end
    chk("bp_back_to_back", 64'(n), 64'(4));
    req_addr = 11'h054;
    req_wdata = 32'hB0000004;
    chk("bp_level_full", 64'(level), 64'(4));
    chk("bp_ready_low", 64'(req_ready), 64'(0));
    repeat (3) tick();
    chk("bp_still_full", 64'({req_ready, level}), 64'({1'b0, 3'd4}));
    chk("bp_rsp_stable", 64'({rsp_valid, rsp_addr, rsp_rdata}), 64'({1'b1, 11'h040, 32'hC0DE0040}));
    rsp_ready = 1'b1;
    n = 0;
    while (!req_ready && n < 20) begin tick(); n++; end
    chk("bp_ready_back", 64'(req_ready), 64'(1));
    tick();
    req_valid = 1'b0;
    n = 0;
    while (sbq.size() != 0 && n < 200) begin tick(); n++; end
    chk("bp_drained", 64'(sbq.size()), 64'(0));
    repeat (2) tick();

    // timeout on the second instance whose controller never goes busy
    req_write = 1'b0;
    req_addr = 11'h02A;
    t_valid = 1'b1;
    tick();
    t_valid = 1'b0;
    tick();
    chk("tmo_issue", 64'({t_mem_start, t_mem_we, t_mem_re}), 64'(3'b101));
    n = 0;
    while (t_mem_start && n < 100) begin tick(); n++; end
    chk("tmo_cycles", 64'(n), 64'(16));
    chk("tmo_rsp", 64'({t_rsp_valid, t_rsp_timeout, t_rsp_rdata, t_rsp_addr, t_rsp_write}),
        64'({1'b1, 1'b1, 32'h0, 11'h02A, 1'b0}));
    chk("tmo_strobes_clear", 64'({t_mem_start, t_mem_we, t_mem_re}), 64'(0));
    t_rsp_ready = 1'b1;
    tick();
    t_rsp_ready = 1'b0;
    chk("tmo_rsp_drop", 64'(t_rsp_valid), 64'(0));

    // reset during WAIT with two reads still queued
    dly = 1;
    len = 20;
    for (int i = 0; i < 3; i++) begin
      req_valid = 1'b1;
      req_write = 1'b0;
      req_addr = 11'h300 + 11'(i);
      tick();
    end
    req_valid = 1'b0;
    n = 0;
    while (!(mem_read_enable && !mem_start) && n < 20) begin tick(); n++; end
    chk("rst_in_wait", 64'({mem_read_enable, mem_start, level}), 64'({1'b1, 1'b0, 3'd2}));
    rst_n = 1'b0;
    #1;
    chk("rst_rsp_zero", 64'({rsp_valid, rsp_write, rsp_addr, rsp_rdata, rsp_timeout, req_ready, level}), 64'(0));
    chk("rst_mem_zero", 64'({mem_start, mem_write_enable, mem_read_enable, mem_address, mem_data_in}), 64'(0));
    sbq.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ready_back", 64'(req_ready), 64'(1));
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (rsp_valid || mem_start) seen++;
      tick();
    end
    chk("rst_no_response", 64'(seen), 64'(0));

    // random traffic with toggling back-pressure and random controller latency
    rand_lat = 1'b1;
    p0 = pushes;
    r0 = resps;
    n = 0;
    while (pushes - p0 < 1000 && n < 40000) begin
      req_valid = 1'($urandom_range(0, 1));
      req_write = 1'($urandom_range(0, 1));
      req_addr = 11'($urandom_range(0, 15));
      req_wdata = $urandom;
      rsp_ready = $urandom_range(0, 3) != 0;
      tick();
      n++;
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    n = 0;
    while (sbq.size() != 0 && n < 500) begin tick(); n++; end
    chk("rand_pushes", 64'(pushes - p0), 64'(1000));
    chk("rand_responses", 64'(resps - r0), 64'(1000));
    chk("rand_drained", 64'(sbq.size()), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fram_req_queue.md
FRAM_REQ_QUEUE -- requirements
Module: fram_req_queue

Interface
REQ-001 Parameters: DEPTH, 4, request FIFO entries (power of 2, >=2); ADDR_W, 11, FRAM byte address width; DATA_W, 32, data word width; TIMEOUT, 65535, max cycles per memory operation (16-bit).
REQ-002 clk  input  1  single clock, all state on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 req_valid  input  1  upstream request present.
REQ-005 req_ready  output  1  FIFO can accept a request.
REQ-006 req_write  input  1  1 = write, 0 = read.
REQ-007 req_addr  input  ADDR_W  FRAM address.
REQ-008 req_wdata  input  DATA_W  write data, ignored for reads.
REQ-009 rsp_valid  output  1  response present.
REQ-010 rsp_ready  input  1  downstream accepts response.
REQ-011 rsp_write, rsp_addr, rsp_rdata, rsp_timeout  output  1/ADDR_W/DATA_W/1  echoed op, address, read data, timeout flag.
REQ-012 mem_start, mem_write_enable, mem_read_enable  output  1 each  command strobes to memory controller.
REQ-013 mem_address  output  ADDR_W; mem_data_in  output  DATA_W  command operands.
REQ-014 mem_busy  input  1; mem_data_out  input  DATA_W  controller status and read data.
REQ-015 level  output  clog2(DEPTH)+1  current FIFO occupancy.

Function
REQ-016 FIFO: push when req_valid && req_ready; req_ready = (level != DEPTH), registered-state only; a pop in the same cycle does not raise req_ready when full.
REQ-017 No bypass: a request pushed into an empty FIFO is visible to the FSM the following cycle.
REQ-018 Simultaneous push and pop: level unchanged; pointers wrap modulo DEPTH.
REQ-019 FSM states IDLE, ISSUE, WAIT, RESP; exactly one operation in flight.
REQ-020 IDLE: if level != 0, pop head, register addr/wdata/op into mem_* outputs, go ISSUE; else stay.
REQ-021 ISSUE: mem_start=1 and mem_write_enable=op, mem_read_enable=!op; on mem_busy=1 clear mem_start, keep enable, go WAIT.
REQ-022 WAIT: on mem_busy=0 clear enables, capture mem_data_out into rsp_rdata if read (0 if write), rsp_timeout=0, go RESP.
REQ-023 Timeout: 16-bit counter cleared on entering ISSUE, increments in ISSUE/WAIT; at count == TIMEOUT-1 clear all mem strobes, rsp_rdata=0, rsp_timeout=1, go RESP.
REQ-024 RESP: rsp_valid=1, rsp_* stable until rsp_ready=1; on accept go IDLE, rsp_valid=0 next cycle.
REQ-025 Latency: request into empty FIFO at cycle 0 -> mem_start high at cycle 2 (IDLE pop cycle 1, ISSUE cycle 2).
REQ-026 mem_start and the active enable are never asserted outside ISSUE/WAIT; mem_write_enable and mem_read_enable never both high.
REQ-027 mem_busy already high on ISSUE entry counts as acknowledge (WAIT next cycle).
REQ-028 Back-pressure: rsp_ready=0 stalls FSM in RESP; FIFO keeps accepting until full.

Reset
REQ-029 rst_n low asynchronously clears: FIFO pointers, level=0, req_ready=0 during reset then 1 after, FSM=IDLE, timeout counter=0, all mem_* outputs=0, rsp_valid=0, rsp_*=0.
REQ-030 Reset mid-operation abandons in-flight and queued requests; no response is emitted for them.

Verification
REQ-031 Write addr 0x005 data 0xA5A5A5A5, busy model 1 cycle after start for 20 cycles -> mem_start at cycle 2, mem_write_enable=1, rsp_valid with rsp_write=1, rsp_rdata=0, rsp_timeout=0.
REQ-032 Read addr 0x005, model returns 0xA5A5A5A5 -> rsp_rdata=0xA5A5A5A5, rsp_addr=0x005, mem_read_enable only.
REQ-033 Push 5 requests back-to-back, rsp_ready=0 -> req_ready low after 4 accepted (level=4), FIFO order preserved on release.
REQ-034 Model never asserts busy, TIMEOUT=16 -> rsp_timeout=1 after 16 cycles in ISSUE, rsp_rdata=0, strobes cleared.
REQ-035 rst_n low during WAIT with 2 queued -> all outputs 0 immediately, level=0, no response after release.
REQ-036 Random push/pop with rsp_ready toggling 1000 ops -> responses match a reference queue, no simultaneous enables.
